// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - receive FIFO read port of uart_rx_param
interface uart_rx_param_if;
    logic       rd_en;
    logic [8:0] rd_data;
    logic       rd_parity_err;
    logic       rd_framing_err;
    logic       rd_valid;

    modport master (input rd_en, output rd_data, rd_parity_err, rd_framing_err, rd_valid);
    modport slave  (output rd_en, input rd_data, rd_parity_err, rd_framing_err, rd_valid);
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with per-word error flags in a receive FIFO
// Optional break detection is compiled in with UART_RX_BREAK_DETECT_EN.
module uart_rx_param #(
    parameter int OVERSAMPLE  = 16,
    parameter int FILTER_TAPS = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            baud_tick,
    input  logic            rx,
    input  logic [3:0]      data_bits,
    input  logic [1:0]      parity_mode,
    input  logic            stop2,
    uart_rx_param_if.master rd,
    output logic [4:0]      fifo_level,
    output logic            overflow,
    input  logic            clear_overflow,
    output logic            rx_idle,
    output logic            rx_break
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    logic                   sync1, sync2;
    logic [FILTER_TAPS-1:0] window;
    logic [2:0]             ones;
    logic                   rx_f;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [3:0]    bit_cnt;
    logic [3:0]    cfg_bits;
    logic [1:0]    cfg_par;
    logic          cfg_stop2;
    logic [8:0]    data_sh;
    logic          par_bit;
    logic          frame_fe;

    logic          parity_en, tick_end, final_stop, brk_hit, hold_break;
    logic          pe_now, fe_now, push;
    logic [10:0]   push_word;

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          full, empty, do_pop, do_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            window <= '1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            if (baud_tick)
                window <= (window << 1) | FILTER_TAPS'(sync2);
        end
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < FILTER_TAPS; i++)
            ones = ones + 3'(window[i]);
        rx_f = (ones > 3'(FILTER_TAPS / 2));
    end

    assign parity_en  = (cfg_par == 2'b01) || (cfg_par == 2'b10);
    assign tick_end   = baud_tick && (tcnt == LAST);
    assign final_stop = tick_end && (((state == STOP1) && !cfg_stop2) || (state == STOP2));
    // Even parity flags an odd total of ones, odd parity an even total.
    assign pe_now     = parity_en && (((^data_sh) ^ par_bit) == (cfg_par == 2'b01));
    assign fe_now     = frame_fe | ~rx_f;
    assign push_word  = {fe_now, pe_now, data_sh};

`ifdef UART_RX_BREAK_DETECT_EN
    logic in_break;
    assign brk_hit    = (state == STOP1) && (data_sh == 9'd0) && !(parity_en && par_bit) && !rx_f;
    assign hold_break = in_break;
    assign rx_break   = in_break;
`else
    assign brk_hit    = 1'b0;
    assign hold_break = 1'b0;
    assign rx_break   = 1'b0;
`endif

    assign push = final_stop && !brk_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tcnt      <= '0;
            bit_cnt   <= '0;
            cfg_bits  <= 4'd8;
            cfg_par   <= 2'b00;
            cfg_stop2 <= 1'b0;
            data_sh   <= '0;
            par_bit   <= 1'b0;
            frame_fe  <= 1'b0;
            rx_idle   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            in_break  <= 1'b0;
`endif
        end else begin
            rx_idle <= (state == IDLE);
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (hold_break) begin
`ifdef UART_RX_BREAK_DETECT_EN
                            // Break ends after a full bit time of continuous idle line.
                            if (!rx_f)
                                tcnt <= '0;
                            else if (tcnt == LAST) begin
                                tcnt     <= '0;
                                in_break <= 1'b0;
                            end else
                                tcnt <= tcnt + 1'b1;
`endif
                        end else if (!rx_f) begin
                            cfg_bits  <= (data_bits >= 4'd5 && data_bits <= 4'd9) ? data_bits : 4'd8;
                            cfg_par   <= parity_mode;
                            cfg_stop2 <= stop2;
                            tcnt      <= '0;
                            state     <= START;
                            rx_idle   <= 1'b0;
                        end
                    end
                    START: begin
                        if (tcnt == HALF) begin
                            if (rx_f) begin
                                state   <= IDLE;
                                rx_idle <= 1'b1;
                            end else begin
                                tcnt     <= '0;
                                bit_cnt  <= '0;
                                data_sh  <= '0;
                                par_bit  <= 1'b0;
                                frame_fe <= 1'b0;
                                state    <= DATA;
                            end
                        end else
                            tcnt <= tcnt + 1'b1;
                    end
                    DATA: begin
                        if (tcnt == LAST) begin
                            tcnt             <= '0;
                            data_sh[bit_cnt] <= rx_f;
                            bit_cnt          <= bit_cnt + 4'd1;
                            if (bit_cnt == cfg_bits - 4'd1)
                                state <= parity_en ? PARITY : STOP1;
                        end else
                            tcnt <= tcnt + 1'b1;
                    end
                    PARITY: begin
                        if (tcnt == LAST) begin
                            tcnt    <= '0;
                            par_bit <= rx_f;
                            state   <= STOP1;
                        end else
                            tcnt <= tcnt + 1'b1;
                    end
                    STOP1: begin
                        if (tcnt == LAST) begin
                            tcnt     <= '0;
                            frame_fe <= ~rx_f;
                            if (brk_hit || !cfg_stop2) begin
`ifdef UART_RX_BREAK_DETECT_EN
                                in_break <= brk_hit;
`endif
                                state   <= IDLE;
                                rx_idle <= 1'b1;
                            end else
                                state <= STOP2;
                        end else
                            tcnt <= tcnt + 1'b1;
                    end
                    STOP2: begin
                        if (tcnt == LAST) begin
                            tcnt    <= '0;
                            state   <= IDLE;
                            rx_idle <= 1'b1;
                        end else
                            tcnt <= tcnt + 1'b1;
                    end
                    default: begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign full    = (count == 5'(FIFO_DEPTH));
    assign empty   = (count == 5'd0);
    assign do_pop  = rd.rd_en && !empty;
    // A full FIFO still accepts a push when the head leaves in the same clock.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + 5'(do_push) - 5'(do_pop);
            if (clear_overflow)
                overflow <= 1'b0;
            else if (push && !do_push)
                overflow <= 1'b1;
        end
    end

    assign fifo_level        = count;
    assign rd.rd_valid       = !empty;
    assign rd.rd_data        = empty ? 9'd0 : mem[rd_ptr][8:0];
    assign rd.rd_parity_err  = !empty && mem[rd_ptr][9];
    assign rd.rd_framing_err = !empty && mem[rd_ptr][10];
endmodule
